div_unit: RTL
=============

Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider. It is the responder for the DIV/DIVU request interface driven by the execute stage.
- EX raises a start request with two operands and holds it. div_unit iterates one quotient bit per cycle and returns a 64-bit {remainder, quotient} with ready_o.
- EX then forwards the result to HI/LO through its normal hilo write path.
- Stall generation stays in EX and ctrl. div_unit only exposes the handshake.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset (`RstEnable == 1'b1)
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start
- opdata1_i  input  WIDTH  dividend; sampled at start
- opdata2_i  input  WIDTH  divisor; sampled at start
- start_i  input  1  request; EX holds it high until it sees ready_o
- annul_i  input  1  cancel an in-flight division (flush/exception)
- result_o  output  2*WIDTH  {remainder[63:32], quotient[31:0]}
- ready_o  output  1  result valid

Behaviour:
- Reset (asynchronous, any state): state=DivFree, cnt=0, result_o=0, ready_o=0. Reset mid-division discards all work.
- States: DivFree, DivByZero, DivOn, DivEnd.
- DivFree, start_i=1 and annul_i=0:
  - Latch signed_div_i and operands.
  - If divisor==0, go to DivByZero.
  - Otherwise go to DivOn with cnt=0 and partial remainder=0.
  - For signed operations, latch the absolute values (two's-complement negate when the MSB is set). Negating 0x80000000 yields 0x80000000, treated as unsigned.
- DivFree, any other input: stay; ready_o=0, result_o=0.
- DivByZero: next edge goes to DivEnd with result_o=0 and ready_o=1.
- DivOn, per edge (restoring radix-2):
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor from rem using a WIDTH+1-bit subtract.
  - If non-negative, keep the difference and shift in quotient bit 1; else keep rem and shift in 0.
  - cnt increments.
- DivOn, on the edge performing iteration cnt==31:
  - Apply sign fix-up. For signed operations, the quotient is negated if dividend sign ^ divisor sign; the remainder is negated if the dividend sign is set.
  - Register result_o, set ready_o=1, go to DivEnd.
- Latency: the start-sampling edge is E0. For a nonzero divisor, ready_o rises after E32 (33 edges). For divide by zero, ready_o rises after E1.
- Abort: in DivOn or DivByZero, annul_i=1 or start_i=0 sends the block to DivFree on the next edge. ready_o is never raised and result_o stays 0.
- DivEnd:
  - Hold result_o and ready_o=1 while start_i=1, regardless of operand changes.
  - On start_i=0, go to DivFree with ready_o=0 and result_o=0.
  - annul_i is ignored in DivEnd; the result is already complete.
- A new request is accepted no earlier than the edge after the return to DivFree. Back-to-back operations therefore need start_i low for at least one cycle.
- Operand changes while busy have no effect; only the values latched at E0 are used.
- Quotient/remainder identity: dividend == quotient*divisor + remainder. The remainder takes the dividend's sign (MIPS semantics).

Optional Feature:
- Macro: DIV_ZERO_FLAG_EN.
- When defined:
  - Adds output port div_zero_o (1 bit), reset value 0.
  - div_zero_o is set to 1 together with ready_o when the DivByZero path was taken.
  - It is cleared when returning to DivFree.
- When undefined: the port does not exist, and divide by zero behaves silently (result 0, ready after E1).

Test Plan:
- Unsigned: signed_div_i=0, 100 / 7, start held → ready_o after exactly 33 edges; result_o=64'h00000002_0000000E; ready_o and result held until start_i drops, then both 0 the next cycle.
- Signed: -7 (FFFFFFF9) / 2 → result_o=64'hFFFFFFFF_FFFFFFFD. Signed 7 / -2 → 64'h00000001_FFFFFFFD.
- Edge case: signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Divide by zero: 1234 / 0 → ready_o after 2 edges, result_o=0; with DIV_ZERO_FLAG_EN, div_zero_o=1 and it clears after start_i falls.
- Annul: annul_i=1 for one cycle at cycle 10 of DivOn → no ready_o pulse. start_i dropped for one cycle, then 9/3 issued → result_o=64'h00000000_00000003 after 33 edges.
- Reset: assert rst mid-DivOn (cycle 15), asynchronously between edges → ready_o=0 and result_o=0 immediately; after release with start_i low, the block is idle.

Source files
------------

// File: rtl/div_unit.sv
// Restoring radix-2 32-bit DIV/DIVU responder; optional DIV_ZERO_FLAG_EN adds div_zero_o.
// Latency: ready_o after 33 edges from the start-sampling edge (2 edges for a zero divisor).
// Backpressure: result and ready_o held while start_i stays high; start_i low or annul_i aborts work.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic               div_zero_o
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {DivFree, DivByZero, DivOn, DivEnd} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
`ifdef DIV_ZERO_FLAG_EN
  logic               zero_q, zero_d;
`endif

  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   quo_fix;

  // One iteration: shift {rem, dividend} left and trial-subtract the divisor from the top.
  always_comb begin
    trial   = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
    rem_nxt = trial[WIDTH] ? {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]} : trial[WIDTH-1:0];
    quo_nxt = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
    quo_fix = (s1_q ^ s2_q) ? -quo_nxt : quo_nxt;
    rem_fix = s1_q ? -rem_nxt : rem_nxt;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    result_d = result_q;
    ready_d  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
    zero_d   = zero_q;
`endif
    case (state_q)
      DivFree: begin
        ready_d  = 1'b0;
        result_d = '0;
`ifdef DIV_ZERO_FLAG_EN
        zero_d   = 1'b0;
`endif
        if (start_i && !annul_i) begin
          // Signs only matter for DIV; 0x80000000 negates to itself and is then used as unsigned.
          s1_d    = signed_div_i & opdata1_i[WIDTH-1];
          s2_d    = signed_div_i & opdata2_i[WIDTH-1];
          dvd_d   = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
          dvs_d   = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = (opdata2_i == '0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        if (annul_i || !start_i) begin
          state_d = DivFree;
        end else begin
          state_d  = DivEnd;
          result_d = '0;
          ready_d  = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
          zero_d   = 1'b1;
`endif
        end
      end
      DivOn: begin
        if (annul_i || !start_i) begin
          state_d = DivFree;
        end else begin
          rem_d = rem_nxt;
          dvd_d = quo_nxt;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d  = DivEnd;
            result_d = {rem_fix, quo_fix};
            ready_d  = 1'b1;
          end
        end
      end
      DivEnd: begin
        if (!start_i) begin
          state_d  = DivFree;
          ready_d  = 1'b0;
          result_d = '0;
`ifdef DIV_ZERO_FLAG_EN
          zero_d   = 1'b0;
`endif
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
`ifdef DIV_ZERO_FLAG_EN
      zero_q   <= zero_d;
`endif
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
  assign div_zero_o = zero_q;
`endif

endmodule
